reg_scoreboard: RTL and testbench

- Issue-stage hazard tracker that sits directly upstream of the register file read port in the dynamic pipeline.
- Records every in-flight destination register from issue to writeback.
- Tells the decode stage, per source operand, whether the regfile value is current, must be bypassed, or forces a stall.
- Retirement is driven by the same write-port signals that feed the regfile (we/waddr).

---
 rtl/reg_scoreboard.sv | 108 ++++++++++
 tb/tb_reg_scoreboard.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-stage RAW/WAW hazard tracker with per-register in-flight count and readiness countdown.
// Define SB_STATS_EN to add stall_cycles / raw_events statistics outputs.
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int LAT_W = 3,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [4:0]       id_raddr1,
    input  logic [4:0]       id_raddr2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             id_wen,
    input  logic [4:0]       id_waddr,
    input  logic [LAT_W-1:0] id_lat,
    input  logic             wb_we,
    input  logic [4:0]       wb_waddr,
    output logic             stall,
    output logic             issue,
    output logic             fwd1,
    output logic             fwd2,
    output logic             busy_any
`ifdef SB_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      raw_events
`endif
);
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [LAT_W-1:0] cd_q  [NREG];
    logic [LAT_W-1:0] cd_d  [NREG];
    logic             busy_q, busy_d;
    logic [NREG-1:0]  inc, dec;
    logic             pend1, pend2, raw1, raw2, waw;

    always_comb begin
        pend1 = id_use1 & (id_raddr1 != '0) & (cnt_q[id_raddr1] != '0);
        pend2 = id_use2 & (id_raddr2 != '0) & (cnt_q[id_raddr2] != '0);
        raw1  = pend1 & (cd_q[id_raddr1] != '0);
        raw2  = pend2 & (cd_q[id_raddr2] != '0);
        fwd1  = pend1 & (cd_q[id_raddr1] == '0);
        fwd2  = pend2 & (cd_q[id_raddr2] == '0);
        waw   = id_wen & (id_waddr != '0) & (cnt_q[id_waddr] == '1);
        stall = id_valid & (raw1 | raw2 | waw);
        issue = id_valid & ~stall;
    end

    // r0 is never tracked, so its entry stays at the cleared value forever.
    always_comb begin
        busy_d = 1'b0;
        inc    = '0;
        dec    = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = '0;
            cd_d[r]  = '0;
            if (r != 0 && !flush) begin
                inc[r]   = issue & id_wen & (id_waddr == 5'(r));
                dec[r]   = wb_we & (wb_waddr == 5'(r)) & (cnt_q[r] != '0);
                cnt_d[r] = cnt_q[r] + CNT_W'(inc[r]) - CNT_W'(dec[r]);
                cd_d[r]  = (cnt_d[r] == '0) ? '0 :
                           inc[r] ? id_lat :
                           (cd_q[r] != '0) ? cd_q[r] - LAT_W'(1) : cd_q[r];
            end
            busy_d = busy_d | (cnt_d[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
                cd_q[r]  <= '0;
            end
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cd_q   <= cd_d;
            busy_q <= busy_d;
        end
    end

    assign busy_any = busy_q;

`ifdef SB_STATS_EN
    logic        stall_prev_q;
    logic [31:0] stall_cycles_q, raw_events_q;

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_prev_q   <= 1'b0;
            stall_cycles_q <= '0;
            raw_events_q   <= '0;
        end else begin
            stall_prev_q   <= stall;
            stall_cycles_q <= stall_cycles_q + 32'(stall);
            raw_events_q   <= raw_events_q + 32'(stall & ~stall_prev_q & (raw1 | raw2));
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign raw_events   = raw_events_q;
`endif
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed vector table plus randomized traffic checked against
// a cycle-time reference model of in-flight writes and their ready times.
module tb_reg_scoreboard;
    logic       clk = 0, rst_n = 0, flush = 0, id_valid = 0;
    logic [4:0] id_raddr1 = 0, id_raddr2 = 0, id_waddr = 0, wb_waddr = 0;
    logic       id_use1 = 0, id_use2 = 0, id_wen = 0, wb_we = 0;
    logic [2:0] id_lat = 0;
    logic       stall, issue, fwd1, fwd2, busy_any;
`ifdef SB_STATS_EN
    logic [31:0] stall_cycles, raw_events;
`endif

    reg_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .id_use1(id_use1), .id_use2(id_use2),
        .id_wen(id_wen), .id_waddr(id_waddr), .id_lat(id_lat), .wb_we(wb_we), .wb_waddr(wb_waddr),
        .stall(stall), .issue(issue), .fwd1(fwd1), .fwd2(fwd2), .busy_any(busy_any)
`ifdef SB_STATS_EN
        , .stall_cycles(stall_cycles), .raw_events(raw_events)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v, u1; logic [4:0] a1; logic u2; logic [4:0] a2;
        logic wen; logic [4:0] wa; logic [2:0] lat; logic we; logic [4:0] wba; logic fl;
        logic s, f1, f2, b;
    } vec_t;

    int n_cmp = 0, n_bad = 0;
    int mcnt [32];
    int mready [32];
    int cyc = 0;
    int unsigned m_sc = 0, m_re = 0;
    bit m_prev = 0;
    vec_t tbl [31];

    function automatic vec_t mk(int v, int u1, int a1, int u2, int a2, int wen, int wa, int lat,
                                int we, int wba, int fl, int s, int f1, int f2, int b);
        vec_t t;
        t.v = 1'(v); t.u1 = 1'(u1); t.a1 = 5'(a1); t.u2 = 1'(u2); t.a2 = 5'(a2);
        t.wen = 1'(wen); t.wa = 5'(wa); t.lat = 3'(lat); t.we = 1'(we); t.wba = 5'(wba); t.fl = 1'(fl);
        t.s = 1'(s); t.f1 = 1'(f1); t.f2 = 1'(f2); t.b = 1'(b);
        return t;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.v; id_use1 = t.u1; id_raddr1 = t.a1; id_use2 = t.u2; id_raddr2 = t.a2;
        id_wen = t.wen; id_waddr = t.wa; id_lat = t.lat; wb_we = t.we; wb_waddr = t.wba; flush = t.fl;
    endtask

    function automatic void model_clear();
        foreach (mcnt[i]) mcnt[i] = 0;
    endfunction

    // Called at a negedge with inputs driven; returns at the next negedge.
    task automatic step(input string tag, input bit use_tbl, input vec_t t);
        bit p1, p2, r1, r2, w, es, eb, inc, dec;
        #2;
        p1 = id_use1 && id_raddr1 != 0 && mcnt[id_raddr1] > 0;
        p2 = id_use2 && id_raddr2 != 0 && mcnt[id_raddr2] > 0;
        r1 = p1 && cyc < mready[id_raddr1];
        r2 = p2 && cyc < mready[id_raddr2];
        w  = id_wen && id_waddr != 0 && mcnt[id_waddr] == 3;
        es = id_valid && (r1 || r2 || w);
        eb = 0;
        foreach (mcnt[i]) if (mcnt[i] > 0) eb = 1;
        chk({tag, " stall"}, stall, es);
        chk({tag, " issue"}, issue, id_valid && !es);
        chk({tag, " fwd1"}, fwd1, p1 && !r1);
        chk({tag, " fwd2"}, fwd2, p2 && !r2);
        chk({tag, " busy_any"}, busy_any, eb);
        if (use_tbl) begin
            chk({tag, " tbl_stall"}, stall, t.s);
            chk({tag, " tbl_fwd1"}, fwd1, t.f1);
            chk({tag, " tbl_fwd2"}, fwd2, t.f2);
            chk({tag, " tbl_busy"}, busy_any, t.b);
        end
`ifdef SB_STATS_EN
        chk({tag, " stall_cycles"}, stall_cycles, m_sc);
        chk({tag, " raw_events"}, raw_events, m_re);
`endif
        @(posedge clk);
        m_sc += es;
        if (es && !m_prev && (r1 || r2)) m_re++;
        m_prev = es;
        if (flush) model_clear();
        else for (int r = 1; r < 32; r++) begin
            inc = id_valid && !es && id_wen && id_waddr == 5'(r);
            dec = wb_we && wb_waddr == 5'(r) && mcnt[r] > 0;
            mcnt[r] += int'(inc) - int'(dec);
            if (inc) mready[r] = cyc + 1 + int'(id_lat);
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        vec_t t;
        model_clear();
        foreach (mready[i]) mready[i] = 0;
        tbl[0]  = mk(1,1,5,0,0, 0,0,0, 0,0,0, 0,0,0,0);
        tbl[1]  = mk(1,0,0,0,0, 1,8,2, 0,0,0, 0,0,0,0);
        tbl[2]  = mk(1,1,8,0,0, 0,0,0, 0,0,0, 1,0,0,1);
        tbl[3]  = mk(1,1,8,0,0, 0,0,0, 0,0,0, 1,0,0,1);
        tbl[4]  = mk(1,1,8,0,0, 0,0,0, 0,0,0, 0,1,0,1);
        tbl[5]  = mk(0,1,8,0,0, 0,0,0, 1,8,0, 0,1,0,1);
        tbl[6]  = mk(1,1,8,0,0, 0,0,0, 0,0,0, 0,0,0,0);
        tbl[7]  = mk(1,0,0,0,0, 1,3,0, 0,0,0, 0,0,0,0);
        tbl[8]  = mk(1,0,0,0,0, 1,3,0, 0,0,0, 0,0,0,1);
        tbl[9]  = mk(1,0,0,0,0, 1,3,0, 0,0,0, 0,0,0,1);
        tbl[10] = mk(1,0,0,0,0, 1,3,0, 1,3,0, 1,0,0,1);
        tbl[11] = mk(1,0,0,0,0, 1,3,0, 0,0,0, 0,0,0,1);
        tbl[12] = mk(0,0,0,0,0, 0,0,0, 0,0,1, 0,0,0,1);
        tbl[13] = mk(1,1,3,0,0, 0,0,0, 0,0,0, 0,0,0,0);
        tbl[14] = mk(1,0,0,0,0, 1,4,0, 0,0,0, 0,0,0,0);
        tbl[15] = mk(1,0,0,0,0, 1,4,3, 1,4,0, 0,0,0,1);
        tbl[16] = mk(1,1,4,0,0, 0,0,0, 0,0,0, 1,0,0,1);
        tbl[17] = mk(1,1,4,0,0, 0,0,0, 0,0,0, 1,0,0,1);
        tbl[18] = mk(1,1,4,0,0, 0,0,0, 0,0,0, 1,0,0,1);
        tbl[19] = mk(1,1,4,0,0, 0,0,0, 0,0,0, 0,1,0,1);
        tbl[20] = mk(0,1,4,0,0, 0,0,0, 1,4,0, 0,1,0,1);
        tbl[21] = mk(1,0,0,0,0, 1,0,5, 0,0,0, 0,0,0,0);
        tbl[22] = mk(1,1,0,1,0, 0,0,0, 0,0,0, 0,0,0,0);
        tbl[23] = mk(0,0,0,0,0, 0,0,0, 1,0,0, 0,0,0,0);
        tbl[24] = mk(1,0,0,1,0, 0,0,0, 0,0,0, 0,0,0,0);
        tbl[25] = mk(1,0,0,0,0, 1,10,4, 0,0,0, 0,0,0,0);
        tbl[26] = mk(1,0,0,0,0, 1,11,4, 0,0,0, 0,0,0,1);
        tbl[27] = mk(0,1,10,1,11, 0,0,0, 0,0,1, 0,0,0,1);
        tbl[28] = mk(1,1,10,1,11, 0,0,0, 0,0,0, 0,0,0,0);
        tbl[29] = mk(1,0,0,0,0, 1,12,0, 0,0,0, 0,0,0,0);
        tbl[30] = mk(1,0,0,1,12, 0,0,0, 0,0,0, 0,0,1,1);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 31; i++) begin
            drive(tbl[i]);
            step($sformatf("row%0d", i), 1, tbl[i]);
        end

        // Asynchronous reset in the middle of a countdown.
        t = mk(1,0,0,0,0, 1,6,5, 0,0,0, 0,0,0,0);
        drive(t);
        step("rst_prod", 0, t);
        t = mk(1,1,6,0,0, 0,0,0, 0,0,0, 0,0,0,0);
        drive(t);
        step("rst_cons", 0, t);
        #2 rst_n = 0;
        #1;
        chk("async_rst stall", stall, 0);
        chk("async_rst fwd1", fwd1, 0);
        chk("async_rst busy_any", busy_any, 0);
`ifdef SB_STATS_EN
        chk("async_rst stall_cycles", stall_cycles, 0);
`endif
        model_clear();
        m_sc = 0; m_re = 0; m_prev = 0;
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 1500; i++) begin
            t.v   = 1'($urandom_range(0, 9) < 8);
            t.u1  = 1'($urandom_range(0, 1));
            t.a1  = 5'($urandom_range(0, 7));
            t.u2  = 1'($urandom_range(0, 1));
            t.a2  = 5'($urandom_range(0, 7));
            t.wen = 1'($urandom_range(0, 2) != 0);
            t.wa  = 5'($urandom_range(0, 7));
            t.lat = 3'($urandom_range(0, 3));
            t.we  = 1'($urandom_range(0, 9) < 4);
            t.wba = 5'($urandom_range(0, 7));
            t.fl  = 1'($urandom_range(0, 49) == 0);
            drive(t);
            step("rand", 0, t);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
